// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - opcode field layout, instruction limits and encoder state shared with the decoder
package instr_pkg;

    localparam int OPCODE_W = 12;
    localparam int FIELD_W  = 3;

    localparam int TYPE_MSB  = 11;
    localparam int TYPE_LSB  = 9;
    localparam int SUB_MSB   = 8;
    localparam int SUB_LSB   = 6;
    localparam int REG_A_MSB = 5;
    localparam int REG_A_LSB = 3;
    localparam int REG_B_MSB = 2;
    localparam int REG_B_LSB = 0;

    localparam int NUM_INSTR_TYPES = 6;

    typedef struct packed {
        logic [FIELD_W-1:0] type_f;
        logic [FIELD_W-1:0] sub;
        logic [FIELD_W-1:0] reg_a;
        logic [FIELD_W-1:0] reg_b;
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } enc_state_t;

    function automatic opcode_t pack_opcode(
        input logic [FIELD_W-1:0] type_f,
        input logic [FIELD_W-1:0] sub,
        input logic [FIELD_W-1:0] reg_a,
        input logic [FIELD_W-1:0] reg_b
    );
        opcode_t op;
        op.type_f = type_f;
        op.sub    = sub;
        op.reg_a  = reg_a;
        op.reg_b  = reg_b;
        return op;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with synchronous flush; read data is the head entry
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

    // Extra pointer MSB tells a full FIFO apart from an empty one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction fields into opcodes and streams them to program memory; ENCODER_CHECK_EN enables type checking
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [2:0]        in_sub,
    input  logic [2:0]        in_reg_a,
    input  logic [2:0]        in_reg_b,
    input  logic              mem_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [11:0]       mem_wr_data,
    output logic [ADDR_W:0]   count,
    output logic              prog_full,
    output logic              err
);

    enc_state_t          state_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                prog_full_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [OPCODE_W-1:0] wr_data_q;

    opcode_t             op_in;
    logic [OPCODE_W-1:0] fifo_head;
    logic                fifo_full, fifo_empty, fifo_flush;
    logic                accept, type_bad, push, pop, last_addr;

    assign op_in    = pack_opcode(in_type, in_sub, in_reg_a, in_reg_b);
    assign in_ready = (state_q == ST_LOAD) && !fifo_full && !start;
    assign accept   = in_valid && in_ready;

`ifdef ENCODER_CHECK_EN
    logic err_q;

    assign type_bad = (int'(in_type) >= NUM_INSTR_TYPES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && type_bad;
        end
    end

    assign err = err_q;
`else
    assign type_bad = 1'b0;
    assign err      = 1'b0;
`endif

    assign push = accept && !type_bad;
    assign pop  = (state_q == ST_LOAD) && !fifo_empty && mem_ready && !start;

    // Once the address space is exhausted, anything still buffered is dropped.
    assign fifo_flush = start || (state_q == ST_FULL);

    assign last_addr = (addr_q == {ADDR_W{1'b1}});
    assign addr_d    = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign count_d   = count_q + {{ADDR_W{1'b0}}, 1'b1};

    sync_fifo #(
        .WIDTH (OPCODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (push),
        .push_data (op_in),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            prog_full_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (start) begin
                state_q     <= ST_LOAD;
                addr_q      <= '0;
                count_q     <= '0;
                prog_full_q <= 1'b0;
            end else if (pop) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= fifo_head;
                addr_q    <= addr_d;
                count_q   <= count_d;
                if (last_addr) begin
                    state_q     <= ST_FULL;
                    prog_full_q <= 1'b1;
                end
            end
        end
    end

    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign count       = count_q;
    assign prog_full   = prog_full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed checks of instr_encoder against a queue-based reference model
module tb_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 4;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_type, in_sub, in_reg_a, in_reg_b;
    logic              mem_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [11:0]       mem_wr_data;
    logic [ADDR_W:0]   count;
    logic              prog_full;
    logic              err;

    instr_encoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_type     (in_type),
        .in_sub      (in_sub),
        .in_reg_a    (in_reg_a),
        .in_reg_b    (in_reg_b),
        .mem_ready   (mem_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .count       (count),
        .prog_full   (prog_full),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a session flag, a word queue and the next address.
    bit          m_active, m_full;
    logic [11:0] m_q[$];
    int          m_addr, m_count;
    bit          e_wr_en, e_err;
    int          e_addr;
    logic [11:0] e_data;
    bit          last_accept;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_full   = 1'b0;
        m_q.delete();
        m_addr   = 0;
        m_count  = 0;
        e_wr_en  = 1'b0;
        e_err    = 1'b0;
        e_addr   = 0;
        e_data   = '0;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_in_ready"}, in_ready, 0);
        check({pfx, "_wr_en"}, mem_wr_en, 0);
        check({pfx, "_wr_addr"}, mem_wr_addr, 0);
        check({pfx, "_wr_data"}, mem_wr_data, 0);
        check({pfx, "_count"}, count, 0);
        check({pfx, "_prog_full"}, prog_full, 0);
        check({pfx, "_err"}, err, 0);
    endtask

    // One clock cycle: drive, check in_ready, advance model at the edge, check outputs.
    task automatic step(input bit v, input int t, input int s, input int a, input int b,
                        input bit mr, input bit st);
        logic [11:0] op;
        bit rdy, bad;
        in_valid  = v;
        in_type   = t[2:0];
        in_sub    = s[2:0];
        in_reg_a  = a[2:0];
        in_reg_b  = b[2:0];
        mem_ready = mr;
        start     = st;
        #1;
        rdy = m_active && !m_full && (m_q.size() < DEPTH) && !st;
        check("in_ready", in_ready, rdy);
        op = t[2:0] * 512 + s[2:0] * 64 + a[2:0] * 8 + b[2:0];
`ifdef ENCODER_CHECK_EN
        bad = (t >= 6);
`else
        bad = 1'b0;
`endif
        last_accept = v && rdy;
        @(posedge clk);
        e_wr_en = 1'b0;
        e_err   = 1'b0;
        if (st) begin
            m_active = 1'b1;
            m_full   = 1'b0;
            m_q.delete();
            m_addr   = 0;
            m_count  = 0;
        end else begin
            if (m_active && !m_full && m_q.size() > 0 && mr) begin
                e_wr_en = 1'b1;
                e_addr  = m_addr;
                e_data  = m_q.pop_front();
                m_addr  = (m_addr + 1) % CAP;
                m_count++;
                if (m_count == CAP) m_full = 1'b1;
            end
            if (last_accept) begin
                if (bad) e_err = 1'b1;
                else     m_q.push_back(op);
            end
            if (m_full) m_q.delete();
        end
        @(negedge clk);
        check("wr_en", mem_wr_en, e_wr_en);
        check("wr_addr", mem_wr_addr, e_addr);
        check("wr_data", mem_wr_data, e_data);
        check("count", count, m_count);
        check("prog_full", prog_full, m_full);
        check("err", err, e_err);
    endtask

    task automatic idle(input bit mr);
        step(1'b0, 0, 0, 0, 0, mr, 1'b0);
    endtask

    initial begin
        int acc;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        in_type = '0; in_sub = '0; in_reg_a = '0; in_reg_b = '0;
        model_reset();
        @(negedge clk);
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);

        // Basic packing
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        step(1'b1, 2, 1, 5, 3, 1'b1, 1'b0);
        idle(1'b1);
        check("pack_data", mem_wr_data, 12'h46B);
        check("pack_wr_en", mem_wr_en, 1);
        check("pack_count", count, 1);
        idle(1'b1);

        // Back-pressure
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, i % 6, i, 7 - i, i + 1, 1'b0, 1'b0);
            acc += int'(last_accept);
        end
        check("bp_accepted", acc, 4);
        for (int i = 0; i < 4; i++) idle(1'b1);
        step(1'b1, 1, 2, 3, 4, 1'b1, 1'b0);
        check("bp_next_accept", last_accept, 1);
        idle(1'b1);

        // Restart with entries buffered
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        step(1'b1, 3, 3, 3, 3, 1'b0, 1'b0);
        step(1'b1, 4, 4, 4, 4, 1'b0, 1'b0);
        step(1'b1, 5, 5, 5, 5, 1'b1, 1'b1);
        check("rs_no_write", mem_wr_en, 0);
        step(1'b1, 1, 1, 1, 1, 1'b1, 1'b0);
        idle(1'b1);
        check("rs_addr", mem_wr_addr, 0);
        check("rs_count", count, 1);

        // Capacity
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < CAP + 4; i++) step(1'b1, i % 6, i, i + 2, i + 5, 1'b1, 1'b0);
        check("cap_prog_full", prog_full, 1);
        check("cap_count", count, CAP);
        check("cap_in_ready", in_ready, 0);
        idle(1'b1);

`ifdef ENCODER_CHECK_EN
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        step(1'b1, 7, 2, 2, 2, 1'b1, 1'b0);
        check("chk_handshake", last_accept, 1);
        check("chk_err", err, 1);
        idle(1'b1);
        check("chk_no_write", mem_wr_en, 0);
        step(1'b1, 0, 1, 2, 3, 1'b1, 1'b0);
        idle(1'b1);
        check("chk_next_wr_en", mem_wr_en, 1);
        check("chk_next_addr", mem_wr_addr, 0);
`endif

        // Randomized traffic
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end

        // Asynchronous reset while a write is in flight
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        step(1'b1, 5, 4, 3, 2, 1'b1, 1'b0);
        idle(1'b1);
        check("ar_pre_wr_en", mem_wr_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("areset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1, 1, 1, 1, 1'b1, 1'b0);
        check("ar_idle_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
